// File: rtl/aes_rnd_sequencer.sv
// Sequencer for the masked AES-128 core and its PRNG: seeding and reseeding, encryption admission, randomness handshake.
// Optional feature: define AES_RESEED_LIMIT_EN to force a fresh seed every RESEED_PERIOD encryptions.
module aes_rnd_sequencer #(
    parameter int SEED_W        = 80,
    parameter int RESEED_PERIOD = 1024,
    parameter int CNT_W         = 16,
    parameter int MAX_RUN       = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEED_W-1:0] seed_in,
    input  logic              seed_valid,
    input  logic              enc_valid,
    output logic              enc_ready,
    output logic              core_valid_in,
    input  logic              core_ready,
    input  logic              core_cipher_valid,
    output logic [SEED_W-1:0] prng_seed,
    output logic              prng_start_reseed,
    output logic              prng_out_ready,
    input  logic              prng_out_valid,
    input  logic              prng_busy,
    output logic              seeded,
    output logic              need_seed,
    output logic [CNT_W-1:0]  enc_count,
    output logic              err_underflow,
    output logic              err_timeout
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);

`ifdef AES_RESEED_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_UNSEEDED,
        S_RESEED,
        S_WAIT_PRNG,
        S_IDLE,
        S_RUN
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [SEED_W-1:0]  r_prng_seed;
    logic [SEED_W-1:0]  r_pend_seed;
    logic               r_pend;
    logic               r_guard;
    logic               r_seeded;
    logic               r_err_underflow;
    logic               r_err_timeout;
    logic [CNT_W-1:0]   r_enc_count;
    logic [RUN_W-1:0]   r_run_cnt;

    logic [CNT_W-1:0]   w_count_inc;
    logic               w_limit_hit;
    logic               w_enc_ready;
    logic               w_handshake;
    logic               w_done;
    logic               w_prng_out_ready;
    logic               w_seed_direct;
    logic               w_take_pend;
    logic               w_set_pend;

    assign w_count_inc      = (r_enc_count == '1) ? r_enc_count : r_enc_count + CNT_W'(1);
    assign w_limit_hit      = LIMIT_EN && (w_count_inc >= CNT_W'(RESEED_PERIOD));
    assign w_handshake      = enc_valid & w_enc_ready;
    assign w_done           = (r_state == S_RUN) & core_cipher_valid;
    assign w_prng_out_ready = (r_state == S_RUN) | w_handshake;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        w_next_state  = r_state;
        w_enc_ready   = 1'b0;
        w_seed_direct = 1'b0;
        w_take_pend   = 1'b0;
        w_set_pend    = 1'b0;
        case (r_state)
            S_UNSEEDED: begin
                if (seed_valid) begin
                    w_seed_direct = 1'b1;
                    w_next_state  = S_RESEED;
                end
            end
            S_RESEED: begin
                w_set_pend   = seed_valid;
                w_next_state = S_WAIT_PRNG;
            end
            S_WAIT_PRNG: begin
                w_set_pend = seed_valid;
                if (!r_guard && !prng_busy && prng_out_valid) begin
                    w_next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (seed_valid) begin
                    w_seed_direct = 1'b1;
                    w_next_state  = S_RESEED;
                end else if (r_pend) begin
                    w_take_pend  = 1'b1;
                    w_next_state = S_RESEED;
                end else begin
                    w_enc_ready = core_ready & prng_out_valid;
                    if (enc_valid && w_enc_ready) begin
                        w_next_state = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_set_pend = seed_valid;
                if (core_cipher_valid) begin
                    if (!w_limit_hit) begin
                        w_next_state = S_IDLE;
                    end else if (r_pend) begin
                        w_take_pend  = 1'b1;
                        w_next_state = S_RESEED;
                    end else begin
                        w_next_state = S_UNSEEDED;
                    end
                end
            end
            default: w_next_state = S_UNSEEDED;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_UNSEEDED;
            r_prng_seed     <= '0;
            r_pend          <= 1'b0;
            r_guard         <= 1'b0;
            r_seeded        <= 1'b0;
            r_err_underflow <= 1'b0;
            r_err_timeout   <= 1'b0;
            r_enc_count     <= '0;
            r_run_cnt       <= '0;
        end else begin
            r_state <= w_next_state;
            r_guard <= (r_state == S_RESEED);

            if (w_seed_direct) begin
                r_prng_seed <= seed_in;
            end else if (w_take_pend) begin
                r_prng_seed <= r_pend_seed;
            end

            // A request arriving while the pending one is consumed stays pending for the next reseed.
            if (w_set_pend) begin
                r_pend <= 1'b1;
            end else if (w_seed_direct || w_take_pend) begin
                r_pend <= 1'b0;
            end

            if (r_state == S_RESEED) begin
                r_enc_count <= '0;
            end else if (w_done) begin
                r_enc_count <= w_count_inc;
            end

            if (r_state == S_WAIT_PRNG && w_next_state == S_IDLE) begin
                r_seeded <= 1'b1;
            end else if (w_next_state == S_UNSEEDED) begin
                r_seeded <= 1'b0;
            end

            if (w_handshake) begin
                r_run_cnt <= RUN_W'(1);
            end else if (r_state == S_RUN && r_run_cnt != RUN_W'(MAX_RUN)) begin
                r_run_cnt <= r_run_cnt + RUN_W'(1);
            end

            if (w_prng_out_ready && !prng_out_valid) begin
                r_err_underflow <= 1'b1;
            end
            if (r_state == S_RUN && !core_cipher_valid && r_run_cnt == RUN_W'(MAX_RUN)) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    // NOTE: no reset on this data register; it is only read while r_pend is set, and r_pend is reset.
    always_ff @(posedge clk) begin
        if (w_set_pend) begin
            r_pend_seed <= seed_in;
        end
    end

    assign enc_ready         = w_enc_ready;
    assign core_valid_in     = w_handshake;
    assign prng_seed         = r_prng_seed;
    assign prng_start_reseed = (r_state == S_RESEED);
    assign prng_out_ready    = w_prng_out_ready;
    assign seeded            = r_seeded;
    assign need_seed         = (r_state == S_UNSEEDED);
    assign enc_count         = r_enc_count;
    assign err_underflow     = r_err_underflow;
    assign err_timeout       = r_err_timeout;

endmodule

// File: doc/aes_rnd_sequencer.md
# aes_rnd_sequencer

Sequencing controller between the user interface, the masked round-based AES-128 core and the PRNG that supplies its fresh randomness. It owns PRNG seeding and reseeding, admits an encryption only when the PRNG is seeded and delivering valid randomness, and drives `prng_out_ready` for exactly the cycles in which the core consumes random bits. It sits beside the core/PRNG pair inside the top-level wrapper and replaces direct user control of the reseed and out-ready pins.

## Interface
- `SEED_W`, 80, PRNG seed width.
- `RESEED_PERIOD`, 1024, encryptions per seed before a fresh seed is mandatory (only with `AES_RESEED_LIMIT_EN`).
- `CNT_W`, 16, width of `enc_count`; must satisfy 2^CNT_W > `RESEED_PERIOD`.
- `MAX_RUN`, 64, cycle budget for one encryption before the `err_timeout` flag is raised.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `seed_in` in SEED_W: new seed value.
- `seed_valid` in 1: seed request; `seed_in` is sampled in the same cycle.
- `enc_valid` in 1: user requests one encryption.
- `enc_ready` out 1: encryption accepted when `enc_valid & enc_ready`.
- `core_valid_in` out 1: start pulse to the AES core.
- `core_ready` in 1: AES core idle.
- `core_cipher_valid` in 1: AES core result strobe.
- `prng_seed` out SEED_W: registered seed value to the PRNG.
- `prng_start_reseed` out 1: one-cycle reseed pulse.
- `prng_out_ready` out 1: randomness consumed this cycle.
- `prng_out_valid` in 1: PRNG output valid.
- `prng_busy` in 1: PRNG reseeding.
- `seeded` out 1: a seed has been loaded and is still usable.
- `need_seed` out 1: encryptions are blocked until a seed arrives.
- `enc_count` out CNT_W: completed encryptions since the last seed.
- `err_underflow` out 1: sticky; set when randomness is consumed while `prng_out_valid` = 0.
- `err_timeout` out 1: sticky; set when RUN lasts longer than MAX_RUN cycles.

## Operation
States are UNSEEDED, RESEED, WAIT_PRNG, IDLE and RUN.

- **UNSEEDED**
  - `need_seed` = 1, `enc_ready` = 0.
  - On `seed_valid`: latch `seed_in` into `prng_seed`, then go to RESEED.
- **RESEED**
  - Lasts exactly one cycle, with `prng_start_reseed` = 1.
  - Clears `enc_count` and goes to WAIT_PRNG.
- **WAIT_PRNG**
  - The first cycle is a guard cycle: exit is ignored.
  - From the second cycle on, exit to IDLE when `prng_busy` = 0 and `prng_out_valid` = 1. `seeded` is set on this transition.
- **IDLE**
  - `enc_ready` = `core_ready & prng_out_valid & ~pend_seed`.
  - On handshake: `core_valid_in` = 1 and `prng_out_ready` = 1 for that same cycle, then go to RUN.
- **RUN**
  - `prng_out_ready` = 1 every cycle.
  - On `core_cipher_valid`: `enc_count` += 1, saturating at all-ones, then go to IDLE.
- **Seeds during RUN**
  - `seed_valid` in WAIT_PRNG or RUN latches the seed into a pending register and sets `pend_seed`. A later request overwrites the earlier one.
  - In IDLE, a set `pend_seed` has priority over `enc_valid`: go to RESEED and clear `pend_seed`.
  - `seed_valid` directly in IDLE goes to RESEED the next cycle. If `enc_valid` arrives in the same cycle, the seed wins and `enc_ready` = 0.
- **Error flags**
  - `err_underflow` is set on any cycle with `prng_out_ready & ~prng_out_valid`. The core is not stalled.
  - `err_timeout` is set when a RUN cycle counter exceeds MAX_RUN. The FSM stays in RUN until `core_cipher_valid`.
  - Both flags clear only on `rst`.

## Timing
- Reset values:
  - state UNSEEDED
  - `need_seed` = 1
  - `prng_seed` = 0
  - every other output = 0
- Reset applies on the first rising edge with `rst` high, including mid-RUN. Any in-flight core result arriving afterwards is ignored.
- From `seed_valid` to IDLE takes at least 3 cycles: RESEED, guard cycle, then the exit check.
- From the handshake cycle, `core_valid_in` is asserted in that same cycle; it is driven combinationally from state and inputs.
- `enc_ready` falls in the cycle after the handshake.
- Back-to-back: if `core_cipher_valid` arrives at cycle N, `enc_ready` can be 1 again at cycle N+1.

## Configuration
- `AES_RESEED_LIMIT_EN` defined:
  - On completion, if `enc_count` reaches RESEED_PERIOD, go to UNSEEDED and clear `seeded`. A pending seed goes to RESEED instead.
- Not defined:
  - No limit is enforced. `enc_count` still saturates, and only user seeds cause a reseed.

## Test plan
- Reset, then `seed_in` = 80'h1234 with `seed_valid` at cycle 5:
  - `prng_start_reseed` is high for cycle 6 only, and `prng_seed` = 80'h1234.
  - `enc_ready` stays 0 until `prng_busy` falls with `prng_out_valid` = 1, with 3 cycles minimum.
- Encryption with a core model of 21-cycle latency:
  - `prng_out_ready` is high for 22 consecutive cycles.
  - `enc_count` goes 0→1.
  - `enc_ready` is 1 again the cycle after `core_cipher_valid`.
- `seed_valid` mid-RUN:
  - The encryption completes.
  - The next cycle enters RESEED and `enc_count` returns to 0.
  - `enc_valid` held high is not accepted until WAIT_PRNG exits.
- Drop `prng_out_valid` for 1 cycle in RUN:
  - `err_underflow` becomes 1 and stays 1 until `rst`.
  - The completion is still counted.
- With `AES_RESEED_LIMIT_EN` and RESEED_PERIOD = 2:
  - After the 2nd completion, `need_seed` = 1, `seeded` = 0 and `enc_ready` = 0.
  - Without the macro, a 3rd encryption is accepted.
- Hold `core_cipher_valid` low for 70 cycles, then assert `rst` mid-RUN:
  - `err_timeout` = 1 at RUN cycle 65.
  - After `rst`, all outputs are at reset values and state is UNSEEDED.
